// File: rtl/control_unit_mc.sv
// Multi-cycle control FSM for the 16-bit core: fetch/decode/execute/memory/writeback
// sequencing with ROM/RAM ready handshakes, wait timeout, branch evaluation, HALT and TRAP.
module control_unit_mc #(
  parameter int INSTR_WIDTH  = 16,
  parameter int OPC_WIDTH    = 4,
  parameter int ALU_OP_WIDTH = 3,
  parameter int COND_WIDTH   = 3,
  parameter int WAIT_LIMIT   = 15,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_ADD = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [INSTR_WIDTH-1:0]  instr,
  input  logic [3:0]              flags,
  input  logic                    rom_ready,
  input  logic                    ram_ready,
  output logic                    rom_req,
  output logic                    ir_load,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic [1:0]              pc_src,
  output logic                    reg_write,
  output logic [1:0]              wb_src,
  output logic                    alu_src_imm,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    flags_load,
  output logic                    ram_req,
  output logic                    ram_we,
  output logic                    halted,
  output logic                    trap,
  output logic [3:0]              state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_HALT   = 4'd5,
    S_TRAP   = 4'd6
  } state_t;

  localparam logic [OPC_WIDTH-1:0] OP_NOP  = OPC_WIDTH'(0);
  localparam logic [OPC_WIDTH-1:0] OP_LI   = OPC_WIDTH'(1);
  localparam logic [OPC_WIDTH-1:0] OP_ADDI = OPC_WIDTH'(2);
  localparam logic [OPC_WIDTH-1:0] OP_LW   = OPC_WIDTH'(3);
  localparam logic [OPC_WIDTH-1:0] OP_SW   = OPC_WIDTH'(4);
  localparam logic [OPC_WIDTH-1:0] OP_ALU  = OPC_WIDTH'(5);
  localparam logic [OPC_WIDTH-1:0] OP_LINK = OPC_WIDTH'(6);
  localparam logic [OPC_WIDTH-1:0] OP_JMP  = OPC_WIDTH'(7);
  localparam logic [OPC_WIDTH-1:0] OP_JPR  = OPC_WIDTH'(8);
  localparam logic [OPC_WIDTH-1:0] OP_BRH  = OPC_WIDTH'(9);
  localparam logic [OPC_WIDTH-1:0] OP_HALT = OPC_WIDTH'(15);

  localparam int CW  = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam int LIM = (WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1;
  localparam logic [CW-1:0] LIM_M1 = CW'(LIM);

  state_t                  state, state_n;
  logic [CW-1:0]           wait_cnt;
  logic [OPC_WIDTH-1:0]    op_q;
  logic [ALU_OP_WIDTH-1:0] func_q;
  logic [COND_WIDTH-1:0]   cond_q;
  logic [OPC_WIDTH-1:0]    op_d;
  logic                    ready_cur;
  logic                    timeout;
  logic                    take;
  logic [2:0]              cond3;
  logic                    fn, fz, fc, fv;

  assign op_d      = instr[INSTR_WIDTH-1 -: OPC_WIDTH];
  assign ready_cur = (state == S_MEM) ? ram_ready : rom_ready;
  // Timeout fires on the cycle the count would reach the limit, so a ready in that cycle still wins.
  assign timeout   = (WAIT_LIMIT != 0) && !ready_cur && (wait_cnt == LIM_M1);
  assign {fn, fz, fc, fv} = flags;
  assign cond3     = 3'(cond_q);
  assign state_o   = state;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_FETCH;
    else         state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      wait_cnt <= '0;
    else if (state_n != state)
      wait_cnt <= '0;
    else if ((state == S_FETCH || state == S_MEM) && !ready_cur)
      wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q   <= '0;
      func_q <= '0;
      cond_q <= '0;
    end else if (state == S_DECODE) begin
      op_q   <= op_d;
      func_q <= instr[ALU_OP_WIDTH-1:0];
      cond_q <= instr[INSTR_WIDTH-OPC_WIDTH-1 -: COND_WIDTH];
    end
  end

  always_comb begin
    take = 1'b0;
    case (cond3)
      3'd0: take = fz;
      3'd1: take = !fz;
      3'd2: take = fn ^ fv;
      3'd3: take = !(fn ^ fv);
      3'd4: take = fc;
      3'd5: take = !fc;
      3'd6: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:
        if (rom_ready)    state_n = S_DECODE;
        else if (timeout) state_n = S_TRAP;
      S_DECODE:
        case (op_d)
          OP_NOP, OP_LINK, OP_JMP, OP_JPR, OP_BRH,
          OP_ADDI, OP_LW, OP_SW, OP_ALU: state_n = S_EXEC;
          OP_LI:                         state_n = S_WB;
          OP_HALT:                       state_n = S_HALT;
          default:                       state_n = S_TRAP;
        endcase
      S_EXEC:
        case (op_q)
          OP_ADDI, OP_ALU: state_n = S_WB;
          OP_LW, OP_SW:    state_n = S_MEM;
          default:         state_n = S_FETCH;
        endcase
      S_MEM:
        if (ram_ready)    state_n = (op_q == OP_LW) ? S_WB : S_FETCH;
        else if (timeout) state_n = S_TRAP;
      S_WB:    state_n = S_FETCH;
      S_HALT:  state_n = S_HALT;
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_TRAP;
    endcase
  end

  always_comb begin
    rom_req     = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    pc_src      = 2'd0;
    reg_write   = 1'b0;
    wb_src      = 2'd0;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    flags_load  = 1'b0;
    ram_req     = 1'b0;
    ram_we      = 1'b0;
    halted      = 1'b0;
    trap        = 1'b0;
    case (state)
      S_FETCH: begin
        rom_req = 1'b1;
        ir_load = rom_ready;
        pc_inc  = rom_ready;
      end
      S_EXEC:
        case (op_q)
          OP_ADDI: begin
            alu_src_imm = 1'b1;
            flags_load  = 1'b1;
          end
          OP_ALU: begin
            alu_op     = func_q;
            flags_load = 1'b1;
          end
          OP_LW, OP_SW: alu_src_imm = 1'b1;
          OP_LINK: begin
            reg_write = 1'b1;
            wb_src    = 2'd3;
          end
          OP_JMP: begin
            pc_load = 1'b1;
            pc_src  = 2'd0;
          end
          OP_JPR: begin
            pc_load = 1'b1;
            pc_src  = 2'd1;
          end
          OP_BRH: begin
            pc_load = take;
            pc_src  = take ? 2'd2 : 2'd0;
          end
          default: ;
        endcase
      S_MEM: begin
        ram_req = 1'b1;
        ram_we  = (op_q == OP_SW);
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_src    = (op_q == OP_LI) ? 2'd1 : (op_q == OP_LW) ? 2'd2 : 2'd0;
      end
      S_HALT:  halted = 1'b1;
      S_TRAP:  trap   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: default instance plus a WAIT_LIMIT=4 instance for timeout cases.
module tb_control_unit_mc;

  logic        clk = 1'b0;
  logic        resetn, resetn4;
  logic [15:0] instr;
  logic [3:0]  flags;
  logic        rom_ready, rom_ready4, ram_ready;

  logic       rom_req, ir_load, pc_inc, pc_load, reg_write, alu_src_imm, flags_load;
  logic       ram_req, ram_we, halted, trap;
  logic [1:0] pc_src, wb_src;
  logic [2:0] alu_op;
  logic [3:0] state_o;

  logic       t_rom_req, t_ir_load, t_pc_inc, t_pc_load, t_reg_write, t_alu_src_imm, t_flags_load;
  logic       t_ram_req, t_ram_we, t_halted, t_trap;
  logic [1:0] t_pc_src, t_wb_src;
  logic [2:0] t_alu_op;
  logic [3:0] t_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  control_unit_mc u_dut (
    .clk(clk), .resetn(resetn), .instr(instr), .flags(flags),
    .rom_ready(rom_ready), .ram_ready(ram_ready),
    .rom_req(rom_req), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_src(pc_src), .reg_write(reg_write), .wb_src(wb_src), .alu_src_imm(alu_src_imm),
    .alu_op(alu_op), .flags_load(flags_load), .ram_req(ram_req), .ram_we(ram_we),
    .halted(halted), .trap(trap), .state_o(state_o)
  );

  control_unit_mc #(.WAIT_LIMIT(4)) u_dut4 (
    .clk(clk), .resetn(resetn4), .instr(instr), .flags(flags),
    .rom_ready(rom_ready4), .ram_ready(ram_ready),
    .rom_req(t_rom_req), .ir_load(t_ir_load), .pc_inc(t_pc_inc), .pc_load(t_pc_load),
    .pc_src(t_pc_src), .reg_write(t_reg_write), .wb_src(t_wb_src), .alu_src_imm(t_alu_src_imm),
    .alu_op(t_alu_op), .flags_load(t_flags_load), .ram_req(t_ram_req), .ram_we(t_ram_we),
    .halted(t_halted), .trap(t_trap), .state_o(t_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] br_instr [6];
  logic [3:0]  br_flags [6];
  logic        br_take  [6];

  initial begin
    br_instr = '{16'h9000, 16'h9000, 16'h9400, 16'h9400, 16'h9C00, 16'h9E00};
    br_flags = '{4'b0100,  4'b0000,  4'b1000,  4'b1001,  4'b0000,  4'b1111};
    br_take  = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};

    resetn = 1'b0; resetn4 = 1'b0;
    rom_ready = 1'b0; rom_ready4 = 1'b0; ram_ready = 1'b0;
    instr = '0; flags = '0;
    step(); step();

    // ROM timeout with WAIT_LIMIT=4
    resetn4 = 1'b1;
    chk("t_reset_state", t_state, 0);
    chk("t_reset_romreq", t_rom_req, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t_wait_state", t_state, 0);
      chk("t_wait_romreq", t_rom_req, 1);
    end
    step();
    chk("t_trap_state", t_state, 6);
    chk("t_trap_flag", t_trap, 1);
    chk("t_trap_romreq", t_rom_req, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t_trap_hold", t_trap, 1);
    end
    resetn4 = 1'b0;
    step();
    chk("t_rst_state", t_state, 0);
    chk("t_rst_trap", t_trap, 0);
    resetn4 = 1'b1;

    // ready on the limit cycle wins over timeout
    for (int i = 0; i < 3; i++) step();
    instr = 16'h0000;
    rom_ready4 = 1'b1;
    #1;
    chk("t_lim_irload", t_ir_load, 1);
    step();
    chk("t_lim_decode", t_state, 1);
    rom_ready4 = 1'b0;
    step();
    chk("t_nop_exec", t_state, 2);
    chk("t_nop_pcload", t_pc_load, 0);
    chk("t_nop_regwr", t_reg_write, 0);
    step();
    chk("t_nop_fetch", t_state, 0);
    resetn4 = 1'b0;

    // reset state of main instance
    chk("rst_state", state_o, 0);
    chk("rst_romreq", rom_req, 1);
    chk("rst_irload", ir_load, 0);
    chk("rst_regwr", reg_write, 0);
    chk("rst_pcload", pc_load, 0);
    chk("rst_ramreq", ram_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_trap", trap, 0);
    resetn = 1'b1;

    // LI: FETCH, DECODE, WB
    instr = 16'h1234; rom_ready = 1'b1;
    #1;
    chk("li_irload", ir_load, 1);
    chk("li_pcinc", pc_inc, 1);
    step();
    chk("li_decode", state_o, 1);
    step();
    chk("li_wb", state_o, 4);
    chk("li_regwr", reg_write, 1);
    chk("li_wbsrc", wb_src, 1);
    step();
    chk("li_fetch", state_o, 0);

    // LW with 3 RAM wait cycles
    instr = 16'h3000;
    step(); step();
    chk("lw_exec", state_o, 2);
    chk("lw_aluimm", alu_src_imm, 1);
    chk("lw_flagsld", flags_load, 0);
    chk("lw_aluop", alu_op, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("lw_mem_state", state_o, 3);
      chk("lw_ramreq", ram_req, 1);
      chk("lw_ramwe", ram_we, 0);
      step();
    end
    ram_ready = 1'b1;
    #1;
    chk("lw_mem_last", ram_req, 1);
    step();
    ram_ready = 1'b0;
    chk("lw_wb", state_o, 4);
    chk("lw_wbsrc", wb_src, 2);
    chk("lw_regwr", reg_write, 1);
    step();
    chk("lw_fetch", state_o, 0);

    // BRH conditions
    for (int i = 0; i < 6; i++) begin
      instr = br_instr[i]; flags = br_flags[i];
      step(); step();
      chk("brh_exec", state_o, 2);
      chk("brh_pcload", pc_load, br_take[i]);
      chk("brh_pcsrc", pc_src, br_take[i] ? 2 : 0);
      chk("brh_regwr", reg_write, 0);
      step();
      chk("brh_fetch", state_o, 0);
    end

    // ALU func=5
    instr = 16'h5005;
    step(); step();
    chk("alu_op", alu_op, 5);
    chk("alu_flagsld", flags_load, 1);
    chk("alu_imm", alu_src_imm, 0);
    step();
    chk("alu_wb", state_o, 4);
    chk("alu_wbsrc", wb_src, 0);
    step();

    // ADDI
    instr = 16'h2007;
    step(); step();
    chk("addi_imm", alu_src_imm, 1);
    chk("addi_op", alu_op, 0);
    chk("addi_flagsld", flags_load, 1);
    step();
    chk("addi_wb", reg_write, 1);
    step();

    // LINK, JMP, JPR
    instr = 16'h6000;
    step(); step();
    chk("link_regwr", reg_write, 1);
    chk("link_wbsrc", wb_src, 3);
    step();
    instr = 16'h7000;
    step(); step();
    chk("jmp_pcload", pc_load, 1);
    chk("jmp_pcsrc", pc_src, 0);
    step();
    instr = 16'h8000;
    step(); step();
    chk("jpr_pcload", pc_load, 1);
    chk("jpr_pcsrc", pc_src, 1);
    step();
    chk("jpr_fetch", state_o, 0);

    // SW zero-wait: back to FETCH after one MEM cycle
    instr = 16'h4000; ram_ready = 1'b1;
    step(); step(); step();
    chk("sw_mem", state_o, 3);
    chk("sw_ramwe", ram_we, 1);
    step();
    chk("sw_fetch", state_o, 0);
    ram_ready = 1'b0;

    // reset during SW wait
    step(); step(); step();
    chk("swr_ramreq", ram_req, 1);
    step(); step();
    chk("swr_mem", state_o, 3);
    resetn = 1'b0;
    step();
    chk("swr_state", state_o, 0);
    chk("swr_ramreq0", ram_req, 0);
    chk("swr_ramwe0", ram_we, 0);
    chk("swr_waitcnt", u_dut.wait_cnt, 0);
    resetn = 1'b1;

    // illegal opcode
    instr = 16'hA000;
    step(); step();
    chk("ill_state", state_o, 6);
    chk("ill_trap", trap, 1);
    chk("ill_romreq", rom_req, 0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;

    // HALT
    instr = 16'hF000;
    step(); step();
    chk("halt_state", state_o, 5);
    chk("halt_flag", halted, 1);
    for (int i = 0; i < 20; i++) begin
      chk("halt_romreq", rom_req, 0);
      step();
    end
    chk("halt_hold", halted, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
